// File: rtl/cube_pkg.sv
// Shared types and width helpers for the finite-difference cube table generator.
package cube_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Third difference of n^3 is constant.
  localparam int D3 = 6;

  // Wide enough that (2^(n_w+1)-1)^3 and its differences never wrap.
  function automatic int c_width(input int n_w);
    return 3 * (n_w + 1);
  endfunction

  function automatic int d_width(input int n_w);
    return 2 * (n_w + 1) + 3;
  endfunction

endpackage

// File: rtl/cube_step.sv
// Finite-difference accumulator: walks n, n^3 and its differences, and formats the result.
module cube_step
  import cube_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              adv,
  input  logic              sat,
  input  logic [N_W-1:0]    n_first,
  output logic              emit,
  output logic              ovf,
  output logic [DATA_W-1:0] res
);

  localparam int CW = c_width(N_W);
  localparam int DW = d_width(N_W);

  logic [N_W:0]  n;
  logic [CW-1:0] c;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n  <= '0;
      c  <= '0;
      d1 <= '0;
      d2 <= '0;
    end else if (init) begin
      n  <= '0;
      c  <= '0;
      d1 <= DW'(1);
      d2 <= DW'(D3);
    end else if (adv) begin
      c  <= c + CW'(d1);
      d1 <= d1 + d2;
      d2 <= d2 + DW'(D3);
      n  <= n + 1'b1;
    end
  end

  assign emit = (n >= {1'b0, n_first});
  assign ovf  = ((c >> DATA_W) != '0);
  assign res  = (sat == MODE_SAT && ovf) ? '1 : c[DATA_W-1:0];

endmodule

// File: rtl/cube_table_gen.sv
// Streams n^3 for COUNT consecutive n to an external write port and keeps a readable local copy.
module cube_table_gen
  import cube_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COUNT     = 11,
  parameter int N_W       = 5,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 20,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    n_first,
  input  logic              sat_mode,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

  state_t              state, state_nx;
  logic [N_W-1:0]      nf_q;
  logic                sat_q;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [COUNT];
  logic                init, adv, emit, ovf, wr_go;
  logic [DATA_W-1:0]   res;

  cube_step #(
    .DATA_W (DATA_W),
    .N_W    (N_W)
  ) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .adv     (adv),
    .sat     (sat_q),
    .n_first (nf_q),
    .emit    (emit),
    .ovf     (ovf),
    .res     (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    init     = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: if (start) begin
        init     = 1'b1;
        state_nx = STEP;
      end
      STEP: begin
        adv = 1'b1;
        if (emit && idx == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign wr_go = (state == STEP) && emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      nf_q     <= '0;
      sat_q    <= MODE_WRAP;
      idx      <= '0;
    end else begin
      wr_en <= wr_go;
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        nf_q     <= n_first;
        sat_q    <= sat_mode;
        overflow <= 1'b0;
        busy     <= 1'b1;
        idx      <= '0;
      end
      if (state == DONE) busy <= 1'b0;
      if (wr_go) begin
        wr_addr <= ADDR_W'(BASE_ADDR + int'(idx));
        wr_data <= res;
        idx     <= idx + 1'b1;
        if (ovf) overflow <= 1'b1;
      end
    end
  end

  // NOTE: the local table is flop-based and must read zero after reset, so it is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < COUNT; k++) mem[k] <= '0;
    end else if (wr_go) begin
      mem[idx] <= res;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < COUNT) rd_data = mem[rd_idx];
  end

endmodule
